gat_bram_load_bridge: RTL and testbench
=======================================

Name: gat_bram_load_bridge

Overview:
- Parametrised successor to the GAT top-level block-design wrapper; sits between the PS register/BRAM interface and gat_top.
- Bridges NUM_CH byte-addressed 32-bit PS write channels to word-addressed, width-truncated core BRAM ports, registered one cycle.
- Counts accepted words per channel against a programmed expected count and raises per-channel load_done itself. Sequences core start and completion with an FSM.
- Provides a latency-aligned, valid-qualified new-feature readback path.

Parameters:
TOP_WIDTH, 32, PS data bus width
NUM_CH, 3, number of load channels (H data, node info, weight)
DATA_W, 20, core-side data width per channel (LSBs of TOP_WIDTH)
ADDR_W, 18, core-side word address width per channel
CNT_W, 19, expected/accepted word counter width
FEAT_W, 32, new-feature word width
FEAT_ADDR_W, 16, core feature word address width
RD_LAT, 2, core feature BRAM read latency in cycles (>=1)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous active-high reset
cfg_start  in  1  start request pulse
cfg_layer  in  1  GAT layer select, latched on accepted cfg_start
exp_cnt  in  NUM_CH*CNT_W  expected word count per channel, latched on accepted cfg_start
s_din  in  NUM_CH*TOP_WIDTH  PS write data
s_ena  in  NUM_CH  PS enable
s_wea  in  NUM_CH  PS write enable
s_addr  in  NUM_CH*(ADDR_W+2)  PS byte address
m_din  out  NUM_CH*DATA_W  core write data
m_ena  out  NUM_CH  core enable
m_wea  out  NUM_CH  core write enable
m_addr  out  NUM_CH*ADDR_W  core word address
load_done  out  NUM_CH  per-channel load complete (to core *_load_done)
core_layer  out  1  latched layer
core_start  out  1  one-cycle start pulse
core_ready  in  1  core finished (level)
busy  out  1  FSM not in IDLE or DONE
done  out  1  FSM in DONE
err_misalign  out  1  sticky: write with s_addr[1:0]!=0
err_overrun  out  1  sticky: write beyond exp_cnt, or write outside LOAD
rd_en  in  1  feature read request
rd_addr  in  FEAT_ADDR_W+2  feature byte address
core_feat_addrb  out  FEAT_ADDR_W  core feature word address
core_feat_dout  in  FEAT_W  core feature data
rd_data  out  FEAT_W  readback data
rd_valid  out  1  readback data valid

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, counters and sticky flags clear. A reset asserted mid-operation aborts immediately to IDLE; in-flight writes and reads are discarded.
- FSM states: IDLE, LOAD, START, RUN, DONE.
- IDLE/DONE -> LOAD on cfg_start: latch exp_cnt and cfg_layer into core_layer, clear counters and sticky errors. cfg_start in LOAD/START/RUN is ignored.
- LOAD -> START when all load_done bits are 1.
- START: core_start=1 for exactly one cycle, then -> RUN.
- RUN -> DONE on the first cycle core_ready=1. core_ready sampled in any other state is ignored.
- Write accepted on channel i iff all of the following hold:
  - s_ena[i] & s_wea[i];
  - state LOAD;
  - s_addr[1:0]==0;
  - cnt[i] < exp_cnt[i].
- Accepted write, 1 cycle later:
  - m_ena[i]=m_wea[i]=1;
  - m_addr[i]=s_addr[ADDR_W+1:2];
  - m_din[i]=s_din[DATA_W-1:0];
  - cnt[i]++.
- Rejected writes: m_ena/m_wea stay 0.
  - Misaligned write sets err_misalign.
  - Write beyond count, or any s_wea outside LOAD, sets err_overrun.
  - Both errors may set in the same cycle.
- s_ena without s_wea is a no-op.
- load_done[i] = (cnt[i]==exp_cnt[i]) while in LOAD..DONE; 0 in IDLE.
  - exp_cnt[i]==0 means channel i is done on LOAD entry. This is used for layer-2 runs that skip the H reload.
  - If all exp_cnt are 0, LOAD lasts one cycle.
- Simultaneous writes on all channels in one cycle are all accepted independently.
- Counter never wraps; it saturates at exp_cnt by the acceptance rule.
- Readback, accepted in any state:
  - core_feat_addrb = rd_addr[FEAT_ADDR_W+1:2], combinational.
  - A valid shift register of depth RD_LAT runs in parallel; rd_valid/rd_data are registered, giving total latency RD_LAT+1 cycles from rd_en.
  - rd_data updates only when rd_valid=1 and holds otherwise.
  - Back-to-back rd_en gives one result per cycle.
  - Misaligned rd_addr is truncated and flags no error.

Decomposition:
- gat_pkg: FSM state enum, DEFAULT_TOP_WIDTH=32, BYTE_ADDR_LSB=2, and per-dataset CNT_W/ADDR_W constants (CORA/CITESEER).
- One sub-module, gat_load_channel: per-channel accept logic, output register, counter and done compare. Instantiated NUM_CH times via generate; error/done bits are OR/AND-reduced in the parent.

Test Plan:
1. exp_cnt={4,2,3}, cfg_start, aligned writes to byte addrs 0,4,8,12 on ch0 -> m_addr 0,1,2,3 each one cycle later; load_done 3'b111 after the last write; core_start pulses once.
2. ch1 write with s_addr=0x6 and s_din=0xFFFFFFFF during LOAD -> no m_ena, err_misalign=1, cnt unchanged; next aligned write gives m_din[1]=0xFFFFF (DATA_W=20).
3. exp_cnt ch2=3, 5 writes -> 3 forwarded, err_overrun=1, load_done[2] stays 1.
4. exp_cnt={0,0,5} for layer 1 -> load_done[1:0]=1 on LOAD entry, core_layer=1; RUN holds until core_ready=1, then done=1.
5. rd_en with rd_addr 0x10,0x14,0x18 back-to-back, RD_LAT=2 -> core_feat_addrb 4,5,6; rd_valid high on cycles 3,4,5 with matching data.
6. rst asserted in LOAD with 2 of 4 writes accepted -> all outputs 0 asynchronously; a new cfg_start restarts counts from 0.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT BRAM load bridge.
package gat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } gat_state_e;

    localparam int DEFAULT_TOP_WIDTH = 32;
    localparam int BYTE_ADDR_LSB     = 2;

    // Dataset sizing: counter must hold the full word count, address one less bit.
    localparam int CORA_CNT_W        = 19;
    localparam int CORA_ADDR_W       = 18;
    localparam int CITESEER_CNT_W    = 20;
    localparam int CITESEER_ADDR_W   = 19;

    function automatic logic is_word_aligned(input logic [1:0] byte_lsb);
        return byte_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/gat_bram_load_bridge_if.sv
// PS write channels in, core BRAM write ports out, all channels packed side by side.
interface gat_bram_load_bridge_if #(
    parameter int TOP_WIDTH = 32,
    parameter int NUM_CH    = 3,
    parameter int DATA_W    = 20,
    parameter int ADDR_W    = 18
);
    logic [NUM_CH*TOP_WIDTH-1:0]  s_din;
    logic [NUM_CH-1:0]            s_ena;
    logic [NUM_CH-1:0]            s_wea;
    logic [NUM_CH*(ADDR_W+2)-1:0] s_addr;
    logic [NUM_CH*DATA_W-1:0]     m_din;
    logic [NUM_CH-1:0]            m_ena;
    logic [NUM_CH-1:0]            m_wea;
    logic [NUM_CH*ADDR_W-1:0]     m_addr;

    modport master (output s_din, s_ena, s_wea, s_addr,
                    input  m_din, m_ena, m_wea, m_addr);
    modport slave  (input  s_din, s_ena, s_wea, s_addr,
                    output m_din, m_ena, m_wea, m_addr);
endinterface

// File: rtl/gat_load_channel.sv
// One load channel: accept check, registered core write port, word counter.
module gat_load_channel
    import gat_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_load,
    input  logic              active,
    input  logic [CNT_W-1:0]  exp_cnt,
    input  logic [DATA_W-1:0] s_din,
    input  logic              s_ena,
    input  logic              s_wea,
    input  logic [ADDR_W+1:0] s_addr,
    output logic [DATA_W-1:0] m_din,
    output logic              m_ena,
    output logic              m_wea,
    output logic [ADDR_W-1:0] m_addr,
    output logic              load_done,
    output logic              misalign,
    output logic              overrun
);
    logic              wr_req, aligned, room, accept;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              m_en_q, m_en_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_din_q, m_din_d;

    always_comb begin
        wr_req   = s_ena & s_wea;
        aligned  = is_word_aligned(s_addr[1:0]);
        room     = cnt_q < exp_cnt;
        accept   = wr_req & in_load & aligned & room;
        misalign = wr_req & ~aligned;
        // A full channel or any write outside LOAD is an overrun, aligned or not.
        overrun  = wr_req & (~in_load | ~room);
        cnt_d    = clr ? '0 : cnt_q + CNT_W'(accept);
        m_en_d   = accept;
        m_addr_d = accept ? s_addr[ADDR_W+BYTE_ADDR_LSB-1:BYTE_ADDR_LSB] : m_addr_q;
        m_din_d  = accept ? s_din : m_din_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            m_en_q   <= 1'b0;
            m_addr_q <= '0;
            m_din_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            m_en_q   <= m_en_d;
            m_addr_q <= m_addr_d;
            m_din_q  <= m_din_d;
        end
    end

    assign m_ena     = m_en_q;
    assign m_wea     = m_en_q;
    assign m_addr    = m_addr_q;
    assign m_din     = m_din_q;
    assign load_done = active & (cnt_q == exp_cnt);

endmodule

// File: rtl/gat_bram_load_bridge.sv
// PS-to-core BRAM load bridge with run sequencing FSM and feature readback pipe.
module gat_bram_load_bridge
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH   = DEFAULT_TOP_WIDTH,
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = 20,
    parameter int ADDR_W      = 18,
    parameter int CNT_W       = 19,
    parameter int FEAT_W      = 32,
    parameter int FEAT_ADDR_W = 16,
    parameter int RD_LAT      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start,
    input  logic                      cfg_layer,
    input  logic [NUM_CH*CNT_W-1:0]   exp_cnt,
    gat_bram_load_bridge_if.slave     bus,
    output logic [NUM_CH-1:0]         load_done,
    output logic                      core_layer,
    output logic                      core_start,
    input  logic                      core_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err_misalign,
    output logic                      err_overrun,
    input  logic                      rd_en,
    input  logic [FEAT_ADDR_W+1:0]    rd_addr,
    output logic [FEAT_ADDR_W-1:0]    core_feat_addrb,
    input  logic [FEAT_W-1:0]         core_feat_dout,
    output logic [FEAT_W-1:0]         rd_data,
    output logic                      rd_valid
);
    gat_state_e                state_q, state_d;
    logic [NUM_CH*CNT_W-1:0]   exp_q, exp_d;
    logic                      layer_q, layer_d;
    logic                      err_mis_q, err_mis_d, err_ovr_q, err_ovr_d;
    logic                      cfg_accept, in_load, active;
    logic [NUM_CH-1:0]         load_done_w, mis_w, ovr_w;
    logic [RD_LAT-1:0]         vld_q, vld_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [FEAT_W-1:0]         rd_data_q, rd_data_d;
    logic                      unused_bits;

    // Upper PS data bits and byte-lane address bits are intentionally dropped.
    assign unused_bits = ^{bus.s_din, rd_addr};

    assign in_load = (state_q == ST_LOAD);
    assign active  = (state_q != ST_IDLE);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        gat_load_channel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .clr       (cfg_accept),
            .in_load   (in_load),
            .active    (active),
            .exp_cnt   (exp_q[gi*CNT_W +: CNT_W]),
            .s_din     (bus.s_din[gi*TOP_WIDTH +: DATA_W]),
            .s_ena     (bus.s_ena[gi]),
            .s_wea     (bus.s_wea[gi]),
            .s_addr    (bus.s_addr[gi*(ADDR_W+2) +: ADDR_W+2]),
            .m_din     (bus.m_din[gi*DATA_W +: DATA_W]),
            .m_ena     (bus.m_ena[gi]),
            .m_wea     (bus.m_wea[gi]),
            .m_addr    (bus.m_addr[gi*ADDR_W +: ADDR_W]),
            .load_done (load_done_w[gi]),
            .misalign  (mis_w[gi]),
            .overrun   (ovr_w[gi])
        );
    end

    always_comb begin
        state_d    = state_q;
        cfg_accept = 1'b0;
        core_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cfg_start) begin
                    state_d    = ST_LOAD;
                    cfg_accept = 1'b1;
                end
            end
            ST_LOAD:  if (&load_done_w) state_d = ST_START;
            ST_START: begin
                core_start = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN:   if (core_ready) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        exp_d     = cfg_accept ? exp_cnt   : exp_q;
        layer_d   = cfg_accept ? cfg_layer : layer_q;
        err_mis_d = ~cfg_accept & (err_mis_q | (|mis_w));
        err_ovr_d = ~cfg_accept & (err_ovr_q | (|ovr_w));

        // Valid travels alongside the core BRAM pipeline; data captured as it emerges.
        vld_d      = RD_LAT'({vld_q, rd_en});
        rd_valid_d = vld_q[RD_LAT-1];
        rd_data_d  = vld_q[RD_LAT-1] ? core_feat_dout : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            exp_q      <= '0;
            layer_q    <= 1'b0;
            err_mis_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
            vld_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            layer_q    <= layer_d;
            err_mis_q  <= err_mis_d;
            err_ovr_q  <= err_ovr_d;
            vld_q      <= vld_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign load_done       = load_done_w;
    assign core_layer      = layer_q;
    assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done            = (state_q == ST_DONE);
    assign err_misalign    = err_mis_q;
    assign err_overrun     = err_ovr_q;
    assign core_feat_addrb = rd_addr[FEAT_ADDR_W+1:2];
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// Scoreboard bench for gat_bram_load_bridge: write forwarding, FSM sequencing, readback latency.
module tb_gat_bram_load_bridge;
    localparam int TOP_WIDTH   = 32;
    localparam int NUM_CH      = 3;
    localparam int DATA_W      = 20;
    localparam int ADDR_W      = 18;
    localparam int CNT_W       = 19;
    localparam int FEAT_W      = 32;
    localparam int FEAT_ADDR_W = 16;
    localparam int RD_LAT      = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      cfg_start = 1'b0;
    logic                      cfg_layer = 1'b0;
    logic [NUM_CH*CNT_W-1:0]   exp_cnt = '0;
    logic [NUM_CH-1:0]         load_done;
    logic                      core_layer, core_start, busy, done;
    logic                      core_ready = 1'b0;
    logic                      err_misalign, err_overrun;
    logic                      rd_en = 1'b0;
    logic [FEAT_ADDR_W+1:0]    rd_addr = '0;
    logic [FEAT_ADDR_W-1:0]    core_feat_addrb;
    logic [FEAT_W-1:0]         core_feat_dout;
    logic [FEAT_W-1:0]         rd_data;
    logic                      rd_valid;

    gat_bram_load_bridge_if #(.TOP_WIDTH(TOP_WIDTH), .NUM_CH(NUM_CH),
                              .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    gat_bram_load_bridge #(
        .TOP_WIDTH(TOP_WIDTH), .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .CNT_W(CNT_W), .FEAT_W(FEAT_W), .FEAT_ADDR_W(FEAT_ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_layer(cfg_layer),
        .exp_cnt(exp_cnt), .bus(bus), .load_done(load_done),
        .core_layer(core_layer), .core_start(core_start), .core_ready(core_ready),
        .busy(busy), .done(done), .err_misalign(err_misalign), .err_overrun(err_overrun),
        .rd_en(rd_en), .rd_addr(rd_addr), .core_feat_addrb(core_feat_addrb),
        .core_feat_dout(core_feat_dout), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [FEAT_W-1:0] feat_fn(input logic [FEAT_ADDR_W-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // Core feature BRAM model with two cycles of read latency.
    logic [FEAT_ADDR_W-1:0] fa_q = '0;
    logic [FEAT_W-1:0]      fd_q = '0;
    always @(posedge clk) begin
        fa_q <= core_feat_addrb;
        fd_q <= feat_fn(fa_q);
    end
    assign core_feat_dout = fd_q;

    int n_cmp = 0;
    int n_err = 0;
    int start_pulses = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct { int ch; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] din; int cyc; } wr_exp_t;
    typedef struct { logic [FEAT_W-1:0] data; int cyc; } rd_exp_t;
    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.m_ena[i]) begin
                    if (wr_q.size() == 0) begin
                        check_eq("wr_spurious", bus.m_ena[i], 0);
                    end else begin
                        wr_exp_t e;
                        e = wr_q.pop_front();
                        check_eq("wr_ch",   i, e.ch);
                        check_eq("wr_wea",  bus.m_wea[i], 1);
                        check_eq("wr_addr", bus.m_addr[i*ADDR_W +: ADDR_W], e.addr);
                        check_eq("wr_din",  bus.m_din[i*DATA_W +: DATA_W], e.din);
                        check_eq("wr_cyc",  cyc, e.cyc);
                        $display("write ch%0d addr 0x%0h din 0x%0h cyc %0d", i,
                                 bus.m_addr[i*ADDR_W +: ADDR_W], bus.m_din[i*DATA_W +: DATA_W], cyc);
                    end
                end
            end
            if (core_start) start_pulses++;
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    check_eq("rd_spurious", rd_valid, 0);
                end else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    check_eq("rd_data", rd_data, r.data);
                    check_eq("rd_cyc",  cyc, r.cyc);
                    $display("read data 0x%0h cyc %0d", rd_data, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.s_ena = '0;
        bus.s_wea = '0;
        cfg_start = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic set_wr(input int ch, input logic [ADDR_W+1:0] addr,
                          input logic [TOP_WIDTH-1:0] din, input bit acc);
        bus.s_ena[ch] = 1'b1;
        bus.s_wea[ch] = 1'b1;
        bus.s_addr[ch*(ADDR_W+2) +: ADDR_W+2] = addr;
        bus.s_din[ch*TOP_WIDTH +: TOP_WIDTH]  = din;
        if (acc) wr_q.push_back('{ch, addr[ADDR_W+1:2], din[DATA_W-1:0], cyc + 1});
    endtask

    task automatic set_rd(input logic [FEAT_ADDR_W+1:0] addr);
        rd_en   = 1'b1;
        rd_addr = addr;
        rd_q.push_back('{feat_fn(addr[FEAT_ADDR_W+1:2]), cyc + RD_LAT + 1});
    endtask

    task automatic start_run(input int e0, input int e1, input int e2, input logic layer);
        cfg_start = 1'b1;
        cfg_layer = layer;
        exp_cnt   = {CNT_W'(e2), CNT_W'(e1), CNT_W'(e0)};
        step();
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 50 && !done; k++) step();
        check_eq(tag, done, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_m_ena"},   bus.m_ena, 0);
        check_eq({tag, "_m_addr"},  bus.m_addr, 0);
        check_eq({tag, "_m_din"},   bus.m_din, 0);
        check_eq({tag, "_ldone"},   load_done, 0);
        check_eq({tag, "_flags"},   {core_layer, core_start, busy, done, err_misalign, err_overrun}, 0);
        check_eq({tag, "_rd"},      {rd_valid, rd_data}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp;
        bus.s_din = '0; bus.s_ena = '0; bus.s_wea = '0; bus.s_addr = '0;
        #2;
        check_idle_outputs("in_reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("after_reset");

        // Channel load with misaligned, overrun and truncated-data cases.
        sp = start_pulses;
        start_run(4, 2, 3, 1'b0);
        check_eq("t1_busy", {busy, done, core_layer}, 3'b100);
        check_eq("t1_ldone_entry", load_done, 3'b000);
        for (int k = 0; k < 4; k++) begin
            set_wr(0, 20'(k * 4), 32'hA000_0000 + 32'(k * 32'h1111), 1'b1);
            step();
        end
        check_eq("t1_ldone_ch0", load_done, 3'b001);
        set_wr(1, 20'h6, 32'hFFFF_FFFF, 1'b0);
        step();
        check_eq("t2_err", {err_misalign, err_overrun}, 2'b10);
        check_eq("t2_ldone", load_done, 3'b001);
        for (int k = 0; k < 5; k++) begin
            set_wr(2, 20'(k * 4), 32'h1234_5000 + 32'(k), k < 3);
            step();
        end
        check_eq("t3_err", {err_misalign, err_overrun}, 2'b11);
        check_eq("t3_ldone", load_done, 3'b101);
        set_wr(1, 20'h0, 32'hFFFF_FFFF, 1'b1);
        step();
        set_wr(1, 20'h4, 32'h0ABC_DEF0, 1'b1);
        step();
        check_eq("t1_ldone_all", load_done, 3'b111);
        step();
        check_eq("t1_core_start", core_start, 1);
        step();
        check_eq("t1_run", {core_start, busy, done}, 3'b010);
        cfg_start = 1'b1;
        exp_cnt   = {CNT_W'(1), CNT_W'(1), CNT_W'(1)};
        step();
        check_eq("t1_cfg_ignored", {busy, load_done}, 4'b1111);
        repeat (3) step();
        check_eq("t1_run_hold", done, 0);
        core_ready = 1'b1;
        wait_done("t1_done");
        core_ready = 1'b0;
        check_eq("t1_done_state", {busy, load_done}, 4'b0111);
        check_eq("t1_start_pulses", start_pulses - sp, 1);

        // Layer-1 run skipping the first two channels; early core_ready is ignored.
        sp = start_pulses;
        start_run(0, 0, 5, 1'b1);
        check_eq("t4_entry", {load_done, core_layer}, 4'b0111);
        check_eq("t4_err_clear", {err_misalign, err_overrun}, 2'b00);
        core_ready = 1'b1;
        step();
        core_ready = 1'b0;
        check_eq("t4_ready_ignored", {busy, done}, 2'b10);
        for (int k = 0; k < 5; k++) begin
            set_wr(2, 20'h100 + 20'(k * 4), 32'hCAFE_0000 + 32'(k), 1'b1);
            step();
        end
        check_eq("t4_ldone_all", load_done, 3'b111);
        repeat (5) step();
        check_eq("t4_run_hold", {busy, done}, 2'b10);
        core_ready = 1'b1;
        wait_done("t4_done");
        core_ready = 1'b0;
        check_eq("t4_start_pulses", start_pulses - sp, 1);

        // All counts zero: LOAD lasts a single cycle.
        start_run(0, 0, 0, 1'b0);
        check_eq("t4b_ldone", load_done, 3'b111);
        step();
        check_eq("t4b_start", core_start, 1);
        core_ready = 1'b1;
        wait_done("t4b_done");
        core_ready = 1'b0;

        // Back-to-back feature reads plus a misaligned one.
        set_rd(18'h10);
        #1 check_eq("t5_addrb0", core_feat_addrb, 4);
        step();
        set_rd(18'h14);
        #1 check_eq("t5_addrb1", core_feat_addrb, 5);
        step();
        set_rd(18'h18);
        #1 check_eq("t5_addrb2", core_feat_addrb, 6);
        step();
        repeat (5) step();
        check_eq("t5_hold", {rd_valid, rd_data}, {1'b0, feat_fn(16'd6)});
        set_rd(18'h1B);
        #1 check_eq("t5_addrb_mis", core_feat_addrb, 6);
        step();
        repeat (5) step();
        check_eq("t5_no_err", {err_misalign, err_overrun}, 2'b00);

        // Asynchronous reset in the middle of a load.
        start_run(4, 0, 0, 1'b1);
        set_wr(0, 20'h0, 32'h0000_1111, 1'b1);
        step();
        set_wr(0, 20'h4, 32'h0000_2222, 1'b0);
        @(posedge clk);
        #2;
        check_eq("t6_pre_rst", {bus.m_ena[0], load_done, core_layer}, 5'b1_110_1);
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_async");
        bus.s_ena = '0; bus.s_wea = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start_run(4, 0, 0, 1'b0);
        check_eq("t6_restart", load_done, 3'b110);
        for (int k = 0; k < 4; k++) begin
            set_wr(0, 20'h40 + 20'(k * 4), 32'h0BAD_0000 + 32'(k), 1'b1);
            step();
        end
        check_eq("t6_ldone", load_done, 3'b111);
        core_ready = 1'b1;
        wait_done("t6_done");
        core_ready = 1'b0;
        repeat (2) step();

        check_eq("wr_q_drained", wr_q.size(), 0);
        check_eq("rd_q_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
